// File: rtl/iter_muldiv_unit.sv
// Iterative multiply/divide unit: UMULL/SMULL (2*WIDTH product) and UDIV/SDIV
// (quotient + remainder). Operates on magnitudes and applies signs at the end.
// UNROLL bits are retired per RUN cycle, so a normal op takes N+1 edges.
//
// Handshake: start is sampled only in IDLE or DONE. busy is high while the
// unit owns its operands (RUN, FIX). done is a one-cycle flag in DONE
// qualifying result_lo/result_hi/div_by_zero. All outputs are registered or
// decoded from the state register.
module iter_muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic             sign_a;
  logic             sign_b;
  logic             dbz_q;
  // Multiply: acc_hi = partial product, acc_lo = multiplier shifting out.
  // Divide:   acc_hi = remainder,       acc_lo = dividend out / quotient in.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mcand;  // |a| for multiply, |b| (divisor) for divide

  // Operand magnitudes at capture time; signs only matter for SMULL/SDIV.
  logic             sa_in;
  logic             sb_in;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign sa_in = op[0] & a[WIDTH-1];
  assign sb_in = op[0] & b[WIDTH-1];
  assign mag_a = sa_in ? -a : a;
  assign mag_b = sb_in ? -b : b;

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  // One RUN cycle worth of unsigned shift-add or restoring-divide steps.
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;

  always_comb begin
    step_hi = acc_hi;
    step_lo = acc_lo;
    sum     = '0;
    rem     = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (!op_q[1]) begin
        sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, mcand} : '0);
        step_lo = {sum[0], step_lo[WIDTH-1:1]};
        step_hi = sum[WIDTH:1];
      end else begin
        rem     = {step_hi, step_lo[WIDTH-1]};
        step_lo = {step_lo[WIDTH-2:0], 1'b0};
        if (rem >= {1'b0, mcand}) begin
          rem        = rem - {1'b0, mcand};
          step_lo[0] = 1'b1;
        end
        step_hi = rem[WIDTH-1:0];
      end
    end
  end

  // Sign fix-up of the magnitude results; also recovers the original dividend.
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   a_orig;

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = (op_q == 2'b01 && (sign_a ^ sign_b)) ? -prod : prod;
    quo_fix  = (op_q == 2'b11 && (sign_a ^ sign_b)) ? -acc_lo : acc_lo;
    rem_fix  = (op_q == 2'b11 && sign_a) ? -acc_hi : acc_hi;
    a_orig   = sign_a ? -acc_lo : acc_lo;
  end

  // Control FSM, datapath registers and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= 2'b00;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dbz_q       <= 1'b0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      mcand       <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            cnt         <= '0;
            op_q        <= op;
            sign_a      <= sa_in;
            sign_b      <= sb_in;
            dbz_q       <= op[1] && (b == '0);
            acc_hi      <= '0;
            acc_lo      <= op[1] ? mag_a : mag_b;
            mcand       <= op[1] ? mag_b : mag_a;
            div_by_zero <= 1'b0;
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (dbz_q) begin
            // Divide by zero bypasses iteration and sign fix-up.
            result_lo   <= '1;
            result_hi   <= a_orig;
            div_by_zero <= 1'b1;
            state       <= DONE;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          if (!op_q[1]) begin
            result_lo <= prod_fix[WIDTH-1:0];
            result_hi <= prod_fix[2*WIDTH-1:WIDTH];
          end else begin
            result_lo <= quo_fix;
            result_hi <= rem_fix;
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
